// File: rtl/serial_duplex_engine.sv
// serial_duplex_engine: parametrised serial shift engine.
// One transaction runs TX only, RX only or full duplex. It uses a
// programmable word width, SCK half-period, bit order and start-qualification
// length. Every output is registered.
module serial_duplex_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned START_HOLD = 3,
    parameter bit          LSB_FIRST  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] transmit_data,
    output logic                  data_tx,
    output logic                  sck_tx,
    input  logic                  data_rx,
    output logic                  sck_rx,
    output logic [DATA_WIDTH-1:0] receive_data,
    output logic                  latch_flag,
    output logic                  finish,
    output logic                  busy
);

    localparam int unsigned PW = $clog2(2 * CLK_DIV);
    localparam int unsigned BW = $clog2(DATA_WIDTH);
    localparam int unsigned QW = $clog2(START_HOLD + 1);

    localparam logic [PW-1:0] PH_RISE  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [QW-1:0] Q_LAST   = QW'(START_HOLD - 1);

    localparam logic [1:0] MODE_TX   = 2'b00;
    localparam logic [1:0] MODE_RX   = 2'b01;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e                state_q;
    logic [QW-1:0]         qcnt_q;
    logic                  armed_q;
    logic [PW-1:0]         phase_q;
    logic [BW-1:0]         bit_q;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] rx_word_q;
    logic                  data_tx_q;
    logic                  sck_tx_q;
    logic                  sck_rx_q;
    logic                  latch_q;
    logic                  finish_q;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] tx_shift_d;
    logic [DATA_WIDTH-1:0] rx_shift_d;
    logic                  first_bit_d;
    logic                  next_bit_d;

    // Bit-order dependent shift paths and the bit presented on data_tx
    always_comb begin
        if (LSB_FIRST) begin
            tx_shift_d  = tx_q >> 1;
            rx_shift_d  = {data_rx, rx_q[DATA_WIDTH-1:1]};
            first_bit_d = transmit_data[0];
            next_bit_d  = tx_shift_d[0];
        end else begin
            tx_shift_d  = tx_q << 1;
            rx_shift_d  = {rx_q[DATA_WIDTH-2:0], data_rx};
            first_bit_d = transmit_data[DATA_WIDTH-1];
            next_bit_d  = tx_shift_d[DATA_WIDTH-1];
        end
    end

    // Control FSM: start qualification, bit/phase timing, registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            qcnt_q    <= '0;
            armed_q   <= 1'b1;
            phase_q   <= '0;
            bit_q     <= '0;
            mode_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_word_q <= '0;
            data_tx_q <= 1'b0;
            sck_tx_q  <= 1'b0;
            sck_rx_q  <= 1'b0;
            latch_q   <= 1'b0;
            finish_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            latch_q  <= 1'b0;
            finish_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!start) begin
                        qcnt_q  <= '0;
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        if (qcnt_q == Q_LAST) begin
                            // Qualified request: consumes the arm whether or not it starts
                            qcnt_q  <= '0;
                            armed_q <= 1'b0;
                            if (mode != MODE_RSVD) begin
                                state_q   <= S_SHIFT;
                                mode_q    <= mode;
                                tx_q      <= transmit_data;
                                rx_q      <= '0;
                                phase_q   <= '0;
                                bit_q     <= '0;
                                latch_q   <= 1'b1;
                                busy_q    <= 1'b1;
                                data_tx_q <= (mode != MODE_RX) ? first_bit_d : 1'b0;
                            end
                        end else begin
                            qcnt_q <= qcnt_q + 1'b1;
                        end
                    end
                end

                S_SHIFT: begin
                    if (phase_q == PH_RISE) begin
                        sck_tx_q <= (mode_q != MODE_RX);
                        sck_rx_q <= (mode_q != MODE_TX);
                        if (mode_q != MODE_TX) begin
                            rx_q <= rx_shift_d;
                        end
                    end
                    if (phase_q == PH_LAST) begin
                        phase_q  <= '0;
                        sck_tx_q <= 1'b0;
                        sck_rx_q <= 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_q   <= S_DONE;
                            data_tx_q <= 1'b0;
                            finish_q  <= 1'b1;
                            if (mode_q != MODE_TX) begin
                                rx_word_q <= rx_q;
                            end
                        end else begin
                            bit_q     <= bit_q + 1'b1;
                            tx_q      <= tx_shift_d;
                            data_tx_q <= (mode_q != MODE_RX) ? next_bit_d : 1'b0;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign data_tx      = data_tx_q;
    assign sck_tx       = sck_tx_q;
    assign sck_rx       = sck_rx_q;
    assign receive_data = rx_word_q;
    assign latch_flag   = latch_q;
    assign finish       = finish_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_serial_duplex_engine.sv
// Bench for serial_duplex_engine. Two instances share the stimulus: one shifts
// MSB first and the other LSB first. A transaction-level model derives every
// output from the position within the transfer. Directed literal checks pin
// that model.
`timescale 1ns/1ps
module tb_serial_duplex_engine;

    localparam int DW   = 8;
    localparam int CD   = 2;
    localparam int SH   = 3;
    localparam int TLEN = DW * 2 * CD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [DW-1:0] tx_word = '0;
    logic          loop_en = 1'b0;
    logic          drv_rx = 1'b0;
    logic          rx_drv_on = 1'b0;
    logic [DW-1:0] rx_word = '0;
    int            rx_idx = 0;

    logic          data_tx0, sck_tx0, sck_rx0, latch0, finish0, busy0;
    logic          data_tx1, sck_tx1, sck_rx1, latch1, finish1, busy1;
    logic [DW-1:0] rd0, rd1;
    logic          data_rx0, data_rx1;

    assign data_rx0 = loop_en ? data_tx0 : drv_rx;
    assign data_rx1 = loop_en ? data_tx1 : drv_rx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_duplex_engine #(.DATA_WIDTH(DW), .CLK_DIV(CD), .START_HOLD(SH), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .transmit_data(tx_word),
        .data_tx(data_tx0), .sck_tx(sck_tx0), .data_rx(data_rx0), .sck_rx(sck_rx0),
        .receive_data(rd0), .latch_flag(latch0), .finish(finish0), .busy(busy0)
    );

    serial_duplex_engine #(.DATA_WIDTH(DW), .CLK_DIV(CD), .START_HOLD(SH), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .transmit_data(tx_word),
        .data_tx(data_tx1), .sck_tx(sck_tx1), .data_rx(data_rx1), .sck_rx(sck_rx1),
        .receive_data(rd1), .latch_flag(latch1), .finish(finish1), .busy(busy1)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rev8(input logic [DW-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
        return r;
    endfunction

    // ---------------- transaction-level model ----------------
    // t = 0 idle, 1..TLEN shifting (1 = latch cycle), TLEN+1 = finish cycle
    int            m_t = 0;
    int            m_cnt = 0;
    bit            m_armed = 1'b1;
    bit            m_valid = 1'b0;
    logic [DW-1:0] m_word = '0;
    logic [1:0]    m_mode = 2'b00;
    logic [DW-1:0] m_hold [2];
    logic [DW-1:0] m_rxexp [2];

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_cnt = 0; m_armed = 1'b1; m_valid = 1'b1;
            m_hold[0] = '0; m_hold[1] = '0;
        end else if (m_t == 0) begin
            if (!start) begin
                m_cnt = 0; m_armed = 1'b1;
            end else if (m_armed) begin
                m_cnt++;
                if (m_cnt == SH) begin
                    m_cnt = 0; m_armed = 1'b0;
                    if (mode != 2'b11) begin
                        m_t = 1; m_word = tx_word; m_mode = mode;
                        m_rxexp[0] = loop_en ? tx_word : rx_word;
                        m_rxexp[1] = loop_en ? tx_word : rev8(rx_word);
                    end
                end
            end
        end else if (m_t <= TLEN) begin
            m_t++;
            if (m_t == TLEN + 1 && m_mode != 2'b00) begin
                m_hold[0] = m_rxexp[0];
                m_hold[1] = m_rxexp[1];
            end
        end else begin
            m_t = 0;
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin : cmp
        int   b;
        logic hi, e_stx, e_srx, e_tx0, e_tx1;
        if (m_valid) begin
            b = 0; hi = 1'b0; e_stx = 1'b0; e_srx = 1'b0; e_tx0 = 1'b0; e_tx1 = 1'b0;
            if (m_t >= 1 && m_t <= TLEN) begin
                b     = (m_t - 1) / (2 * CD);
                hi    = ((m_t - 1) % (2 * CD)) >= CD;
                e_stx = hi && (m_mode != 2'b01);
                e_srx = hi && (m_mode != 2'b00);
                if (m_mode != 2'b01) begin
                    e_tx0 = m_word[DW-1-b];
                    e_tx1 = m_word[b];
                end
            end
            check1("busy0", busy0, m_t != 0);
            check1("busy1", busy1, m_t != 0);
            check1("latch0", latch0, m_t == 1);
            check1("latch1", latch1, m_t == 1);
            check1("finish0", finish0, m_t == TLEN + 1);
            check1("finish1", finish1, m_t == TLEN + 1);
            check1("sck_tx0", sck_tx0, e_stx);
            check1("sck_tx1", sck_tx1, e_stx);
            check1("sck_rx0", sck_rx0, e_srx);
            check1("sck_rx1", sck_rx1, e_srx);
            check1("data_tx0", data_tx0, e_tx0);
            check1("data_tx1", data_tx1, e_tx1);
            check8("rxdata0", rd0, m_hold[0]);
            check8("rxdata1", rd1, m_hold[1]);
        end
    end

    // Serial source: next bit presented after each sck_rx falling edge
    always @(negedge sck_rx0) begin
        if (rx_drv_on && rx_idx < DW - 1) begin
            rx_idx = rx_idx + 1;
            drv_rx = rx_word[DW-1-rx_idx];
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called in the latch cycle; counts cycles until finish and sck_tx pulses
    task automatic run_to_finish(output int ncyc, output int npulse);
        logic prev;
        ncyc = 0; npulse = 0; prev = sck_tx0;
        while (finish0 !== 1'b1 && ncyc < 100) begin
            cyc(1);
            ncyc++;
            if (sck_tx0 && !prev) npulse++;
            prev = sck_tx0;
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n, p, cnt;
        rst = 1'b1;
        cyc(2);
        check1("rst_busy", busy0, 1'b0);
        check1("rst_dtx", data_tx0, 1'b0);
        check8("rst_rxdata", rd0, 8'h00);
        rst = 1'b0;
        cyc(2);

        // TX only, A5
        mode = 2'b00; tx_word = 8'hA5; start = 1'b1;
        cyc(2);
        check1("tx_latch_early", latch0, 1'b0);
        cyc(1);
        check1("tx_latch_c4", latch0, 1'b1);
        check1("tx_first_bit", data_tx0, 1'b1);
        start = 1'b0;
        run_to_finish(n, p);
        check_int("tx_len", n, 32);
        check_int("tx_pulses", p, 8);
        check8("tx_rx_unchanged", rd0, 8'h00);
        cyc(1);
        check1("tx_busy_fall", busy0, 1'b0);
        cyc(2);

        // RX only, 3C driven MSB first
        mode = 2'b01; rx_word = 8'h3C; rx_idx = 0; drv_rx = rx_word[DW-1]; rx_drv_on = 1'b1;
        start = 1'b1;
        cyc(3);
        check1("rx_latch", latch0, 1'b1);
        start = 1'b0;
        run_to_finish(n, p);
        check_int("rx_len", n, 32);
        check_int("rx_no_sck_tx", p, 0);
        check8("rx_word0", rd0, 8'h3C);
        check8("rx_word1", rd1, 8'h3C);
        rx_drv_on = 1'b0;
        cyc(3);

        // Duplex loopback, 5A, both bit orders
        loop_en = 1'b1; mode = 2'b10; tx_word = 8'h5A; start = 1'b1;
        cyc(3);
        check1("dpx_latch", latch0, 1'b1);
        check1("dpx_first_msb", data_tx0, 1'b0);
        check1("dpx_first_lsb", data_tx1, 1'b0);
        start = 1'b0;
        run_to_finish(n, p);
        check8("dpx_word0", rd0, 8'h5A);
        check8("dpx_word1", rd1, 8'h5A);
        loop_en = 1'b0;
        cyc(3);

        // Start held only 2 cycles
        start = 1'b1;
        cyc(2);
        start = 1'b0;
        cnt = 0;
        repeat (6) begin
            cyc(1);
            if (latch0) cnt++;
        end
        check_int("short_start", cnt, 0);

        // Start held 80 cycles: exactly one transfer, then re-arm
        mode = 2'b00; tx_word = 8'h81; start = 1'b1;
        cnt = 0;
        repeat (80) begin
            cyc(1);
            if (latch0) cnt++;
        end
        check_int("long_start_one", cnt, 1);
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(2);
        check1("rearm_early", latch0, 1'b0);
        cyc(1);
        check1("rearm_latch", latch0, 1'b1);
        start = 1'b0;
        run_to_finish(n, p);
        check_int("rearm_len", n, 32);
        cyc(3);

        // Reserved mode
        mode = 2'b11; start = 1'b1;
        cnt = 0;
        repeat (10) begin
            cyc(1);
            if (busy0 || latch0) cnt++;
        end
        check_int("rsvd_idle", cnt, 0);
        start = 1'b0;
        cyc(2);

        // Reset during bit 3 of a duplex FF transfer
        loop_en = 1'b1; mode = 2'b10; tx_word = 8'hFF; start = 1'b1;
        cyc(3);
        check1("rm_latch", latch0, 1'b1);
        start = 1'b0;
        cyc(14);
        check1("rm_sck_high", sck_tx0, 1'b1);
        rst = 1'b1;
        cyc(1);
        check1("rm_busy", busy0, 1'b0);
        check1("rm_sck_tx", sck_tx0, 1'b0);
        check1("rm_sck_rx", sck_rx0, 1'b0);
        check1("rm_dtx", data_tx0, 1'b0);
        check1("rm_finish", finish0, 1'b0);
        check8("rm_rxdata", rd0, 8'h00);
        rst = 1'b0;
        cyc(2);
        tx_word = 8'hC3; start = 1'b1;
        cyc(3);
        check1("post_latch", latch0, 1'b1);
        start = 1'b0;
        run_to_finish(n, p);
        check_int("post_len", n, 32);
        check8("post_word0", rd0, 8'hC3);
        check8("post_word1", rd1, 8'hC3);
        loop_en = 1'b0;
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
